// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers.
// Supports per-requester packet lock and a watchdog on the UART busy handshake.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int ID_WIDTH     = 2,
    parameter int DATA_WIDTH   = 8,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            req_lock,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            ack,
    output logic [ID_WIDTH-1:0]           grant_id,
    output logic                          busy,
    output logic                          start_transmit,
    output logic [DATA_WIDTH-1:0]         data_to_send,
    input  logic                          tx_busy,
    input  logic                          clear_err,
    output logic                          timeout_err
);
    localparam int CNT_W = $clog2(BUSY_TIMEOUT);

    typedef enum logic [1:0] {IDLE, START, WAIT_HI, WAIT_LO} state_t;

    state_t                      state_q, state_d;
    logic [ID_WIDTH-1:0]         grant_q, grant_d;
    logic [ID_WIDTH-1:0]         rr_q, rr_d;
    logic                        lock_q, lock_d;
    logic [DATA_WIDTH-1:0]       data_q, data_d;
    logic                        start_q, start_d;
    logic [NUM_REQ-1:0]          ack_q, ack_d;
    logic                        busy_q, busy_d;
    logic                        terr_q, terr_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;

    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_bytes;
    logic [ID_WIDTH-1:0]         cand, rr_pick, sel;
    logic                        rr_hit, lock_hit;

    assign req_bytes = req_data;

    function automatic logic [ID_WIDTH-1:0] wrap_id(input int v);
        return ID_WIDTH'(v % NUM_REQ);
    endfunction

    // First pending requester at or after rr_q, wrapping around.
    always_comb begin
        rr_hit  = 1'b0;
        rr_pick = '0;
        cand    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = wrap_id(int'(rr_q) + i);
            if (!rr_hit && req[cand]) begin
                rr_hit  = 1'b1;
                rr_pick = cand;
            end
        end
    end

    assign lock_hit = lock_q && req[grant_q];
    assign sel      = lock_hit ? grant_q : rr_pick;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        lock_d  = lock_q;
        data_d  = data_q;
        start_d = 1'b0;
        ack_d   = '0;
        cnt_d   = cnt_q;
        terr_d  = terr_q & ~clear_err;
        case (state_q)
            IDLE: begin
                if (lock_q && !req[grant_q])
                    lock_d = 1'b0;
                // rr_hit is set whenever any req is high, locked owner included.
                if (rr_hit && !tx_busy) begin
                    grant_d    = sel;
                    data_d     = req_bytes[sel];
                    lock_d     = req_lock[sel];
                    rr_d       = wrap_id(int'(sel) + 1);
                    start_d    = 1'b1;
                    ack_d[sel] = 1'b1;
                    state_d    = START;
                end
            end
            START: begin
                cnt_d   = '0;
                state_d = WAIT_HI;
            end
            WAIT_HI: begin
                if (tx_busy) begin
                    state_d = WAIT_LO;
                end else if (cnt_q == CNT_W'(BUSY_TIMEOUT - 1)) begin
                    terr_d  = 1'b1;
                    lock_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_LO: begin
                if (!tx_busy)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            rr_q    <= '0;
            lock_q  <= 1'b0;
            data_q  <= '0;
            start_q <= 1'b0;
            ack_q   <= '0;
            busy_q  <= 1'b0;
            terr_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            lock_q  <= lock_d;
            data_q  <= data_d;
            start_q <= start_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            terr_q  <= terr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ack            = ack_q;
    assign grant_id       = grant_q;
    assign busy           = busy_q;
    assign start_transmit = start_q;
    assign data_to_send   = data_q;
    assign timeout_err    = terr_q;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter among NUM_REQ byte producers, e.g. a NN result streamer, a debug/status reporter and the echo path.
- Round-robin selection, with an optional per-requester lock so multi-byte packets go out uninterrupted.
- Drives the UART start_transmit / data_to_send inputs and sequences on tx_busy.
- Includes a watchdog that recovers if the UART never reports busy.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_WIDTH, 2, width of grant_id; must be >= clog2(NUM_REQ).
- DATA_WIDTH, 8, byte width; matches the UART data_to_send width.
- BUSY_TIMEOUT, 16, clock cycles to wait for tx_busy to rise after start_transmit (>= 2).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  requester i has a byte pending; held until ack[i].
- req_lock  in  NUM_REQ  requester i asks to keep ownership after this byte.
- req_data  in  NUM_REQ*DATA_WIDTH  byte of requester i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- ack  out  NUM_REQ  one-cycle pulse: byte of requester i consumed.
- grant_id  out  ID_WIDTH  index of the current/last owner.
- busy  out  1  arbiter not in IDLE.
- start_transmit  out  1  one-cycle pulse to the UART.
- data_to_send  out  DATA_WIDTH  registered byte to the UART; stable from start_transmit until return to IDLE.
- tx_busy  in  1  UART transmitter busy.
- clear_err  in  1  clears timeout_err.
- timeout_err  out  1  sticky: the UART never went busy.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, ack=0, start_transmit=0, data_to_send=0, grant_id=0, busy=0, timeout_err=0, lock_valid=0, rr_ptr=0. Reset mid-transfer aborts immediately; no further ack is issued for that byte.
- States: IDLE, START, WAIT_HI, WAIT_LO.
- IDLE, selection when any req is high:
  - If lock_valid and req[grant_id] is high, select grant_id.
  - Otherwise select the first high req scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
- IDLE, on selecting requester k, register: data_to_send=req_data[k], grant_id=k, lock_valid=req_lock[k], rr_ptr=(k+1) mod NUM_REQ, next state START.
- IDLE with no req: remain in IDLE.
- Lock release: if lock_valid and req[grant_id]=0 in IDLE, clear lock_valid and apply round-robin in the same cycle.
- START, one cycle: start_transmit=1, ack[grant_id]=1, counter=0, next state WAIT_HI. Only one ack bit is ever high at a time.
- WAIT_HI:
  - tx_busy=1: go to WAIT_LO.
  - Otherwise increment counter.
  - When counter reaches BUSY_TIMEOUT-1 with tx_busy still 0: set timeout_err, clear lock_valid, go to IDLE. The byte counts as consumed (already acked).
- WAIT_LO: when tx_busy=0, go to IDLE.
- Latency: req sampled in IDLE at cycle N gives start_transmit and ack at N+1. The earliest next start_transmit is N+5, with a 1-cycle UART busy.
- Requester contract: after ack, present the next byte or drop req by the following cycle. The arbiter does not re-sample until IDLE, which is at least 2 cycles after ack.
- Simultaneous requests are resolved only by the round-robin order; there is no fixed priority.
- Requester mux: req / req_data changes outside IDLE are ignored.
- timeout_err:
  - clear_err=1 clears it.
  - If clear_err and a new timeout occur in the same cycle, set wins.
- busy = (state != IDLE), registered.
- tx_busy already high in IDLE (UART still busy from an external source): do not start; hold in IDLE until tx_busy=0.

Test Plan:
- Single requester: req[0]=1, req_data=0x55, UART model busy 3 cycles. Expect start_transmit and ack[0] one cycle later, data_to_send=0x55, return to IDLE after busy falls, busy high the whole time.
- Round-robin: req=4'b1111 held, each re-asserted after ack. Expect grant order 0,1,2,3,0 and exactly one ack per byte.
- Lock: req[2] with req_lock[2]=1 for 3 bytes (0xA1,0xA2,0xA3) while req[0] is also high. Expect 0xA1,0xA2,0xA3 back-to-back from 2, then 0 granted when req_lock drops.
- Timeout: UART model never asserts tx_busy. Expect timeout_err=1 BUSY_TIMEOUT cycles after WAIT_HI entry, return to IDLE, next request served; clear_err pulse drops the flag.
- Reset mid-transfer: rst_n low during WAIT_LO. Expect all outputs at reset values immediately and a fresh arbitration from rr_ptr=0 after release.
- External busy: tx_busy=1 while req[1]=1. Expect no start_transmit until tx_busy falls, then a normal grant.
